// File: rtl/gpio_bank_pkg.sv
// Shared constants for the gpio_bank register interface.
package gpio_bank_pkg;

   localparam int unsigned ADDR_W = 3;

   localparam logic [ADDR_W-1:0] REG_OUT      = 3'd0;
   localparam logic [ADDR_W-1:0] REG_OE       = 3'd1;
   localparam logic [ADDR_W-1:0] REG_IN       = 3'd2;
   localparam logic [ADDR_W-1:0] REG_RISE_EN  = 3'd3;
   localparam logic [ADDR_W-1:0] REG_FALL_EN  = 3'd4;
   localparam logic [ADDR_W-1:0] REG_IRQ_STAT = 3'd5;
   localparam logic [ADDR_W-1:0] REG_OUT_SET  = 3'd6;
   localparam logic [ADDR_W-1:0] REG_OUT_CLR  = 3'd7;

endpackage

// File: rtl/gpio_pad.sv
// One GPIO pin: tristate driver, input synchroniser and optional debounce filter.
// Debounce is built only when GPIO_BANK_DEBOUNCE_EN is defined.
module gpio_pad #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic out,
   input  logic oe,
   inout  wire  pad,
   output logic in_f
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
      $error("gpio_pad: parameter out of range");
   end

   assign pad = oe ? out : 1'bz;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   in_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
      end
   end

   assign in_s = sync_q[SYNC_STAGES-1];

`ifdef GPIO_BANK_DEBOUNCE_EN
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic             filt_q;

   // Counter tracks consecutive cycles where in_s disagrees with the filtered value.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else if (in_s == filt_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         cnt_q  <= '0;
         filt_q <= in_s;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign in_f = filt_q;
`else
   assign in_f = in_s;
`endif

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: register bus, per-pin edge detect with sticky IRQ status, WIDTH pads.
// Optional debounce in each pad is enabled by defining GPIO_BANK_DEBOUNCE_EN.
module gpio_bank
   import gpio_bank_pkg::*;
#(
   parameter int unsigned      WIDTH           = 8,
   parameter int unsigned      SYNC_STAGES     = 2,
   parameter logic [WIDTH-1:0] RESET_OE        = '0,
   parameter int unsigned      DEBOUNCE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata,
   output logic              ack,
   output logic              irq,
   inout  wire  [WIDTH-1:0]  pad
);

   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] oe_q, oe_d;
   logic [WIDTH-1:0] rise_en_q, rise_en_d;
   logic [WIDTH-1:0] fall_en_q, fall_en_d;
   logic [WIDTH-1:0] stat_q, stat_d;
   logic [WIDTH-1:0] in_prev_q;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             ack_q;
   logic [WIDTH-1:0] in_f;
   logic [WIDTH-1:0] rise, fall, clr;

   for (genvar i = 0; i < WIDTH; i++) begin : g_pad
      gpio_pad #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_pad (
         .clk  (clk),
         .rst  (rst),
         .out  (out_q[i]),
         .oe   (oe_q[i]),
         .pad  (pad[i]),
         .in_f (in_f[i])
      );
   end

   always_comb begin
      out_d     = out_q;
      oe_d      = oe_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      clr       = '0;
      rdata_d   = '0;

      if (req && we) begin
         case (addr)
            REG_OUT:      out_d     = wdata;
            REG_OE:       oe_d      = wdata;
            REG_RISE_EN:  rise_en_d = wdata;
            REG_FALL_EN:  fall_en_d = wdata;
            REG_IRQ_STAT: clr       = wdata;
            REG_OUT_SET:  out_d     = out_q | wdata;
            REG_OUT_CLR:  out_d     = out_q & ~wdata;
            default:      ;
         endcase
      end

      if (req && !we) begin
         case (addr)
            REG_OUT:      rdata_d = out_q;
            REG_OE:       rdata_d = oe_q;
            REG_IN:       rdata_d = in_f;
            REG_RISE_EN:  rdata_d = rise_en_q;
            REG_FALL_EN:  rdata_d = fall_en_q;
            REG_IRQ_STAT: rdata_d = stat_q;
            default:      rdata_d = '0;
         endcase
      end

      rise   = in_f & ~in_prev_q & rise_en_q;
      fall   = ~in_f & in_prev_q & fall_en_q;
      // New edges are ORed in after the clear so a coincident edge survives W1C.
      stat_d = (stat_q & ~clr) | rise | fall;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q     <= '0;
         oe_q      <= RESET_OE;
         rise_en_q <= '0;
         fall_en_q <= '0;
         stat_q    <= '0;
         in_prev_q <= '0;
         rdata_q   <= '0;
         ack_q     <= 1'b0;
      end else begin
         out_q     <= out_d;
         oe_q      <= oe_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         stat_q    <= stat_d;
         in_prev_q <= in_f;
         rdata_q   <= rdata_d;
         ack_q     <= req;
      end
   end

   assign rdata = rdata_q;
   assign ack   = ack_q;
   assign irq   = |stat_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank (WIDTH=8, SYNC_STAGES=2, RESET_OE=0).
module tb_gpio_bank;
   import gpio_bank_pkg::*;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned SYNC  = 2;
`ifdef GPIO_BANK_DEBOUNCE_EN
   localparam int unsigned DEB = 16;
`else
   localparam int unsigned DEB = 0;
`endif
   localparam int unsigned LAT    = SYNC + DEB;
   localparam int unsigned SETTLE = LAT + 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             req;
   logic             we;
   logic [2:0]       addr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] rdata;
   logic             ack;
   logic             irq;
   wire  [WIDTH-1:0] pad;
   logic [WIDTH-1:0] ext_en;
   logic [WIDTH-1:0] ext_val;

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < WIDTH; g++) begin : g_ext
      assign pad[g] = ext_en[g] ? ext_val[g] : 1'bz;
   end

   gpio_bank #(
      .WIDTH           (WIDTH),
      .SYNC_STAGES     (SYNC),
      .RESET_OE        (8'h00),
      .DEBOUNCE_CYCLES (16)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .ack   (ack),
      .irq   (irq),
      .pad   (pad)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [WIDTH-1:0] d);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
      check("wr_ack", ack, 1);
   endtask

   task automatic read_check(input string tag, input logic [2:0] a, input logic [WIDTH-1:0] exp);
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      req = 1'b0;
      check("rd_ack", ack, 1);
      check(tag, rdata, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      ext_en = 8'hFF; ext_val = 8'h00;
      cycles(3);
      check("rst_ack", ack, 0);
      check("rst_irq", irq, 0);
      check("rst_rdata", rdata, 0);
      rst = 1'b0;
      for (int a = 0; a < 8; a++) read_check("rst_read", 3'(a), 8'h00);
      @(negedge clk);
      check("ack_one_cycle", ack, 0);
      check("rst_irq2", irq, 0);

      // Loopback and OUT set/clear
      bus_write(REG_OUT, 8'hA5);
      ext_en = 8'h00;
      bus_write(REG_OE, 8'hFF);
      check("pad_drive", pad, 8'hA5);
      cycles(SETTLE);
      read_check("in_loop", REG_IN, 8'hA5);
      bus_write(REG_OUT_SET, 8'h0A);
      check("pad_set", pad, 8'hAF);
      bus_write(REG_OUT_CLR, 8'h81);
      check("pad_clr", pad, 8'h2E);
      bus_write(REG_IN, 8'hFF);
      cycles(SETTLE);
      read_check("in_ro", REG_IN, 8'h2E);
      read_check("set_reads0", REG_OUT_SET, 8'h00);

      // Back-to-back reads
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = REG_OUT;
      @(negedge clk);
      check("b2b_ack0", ack, 1);
      check("b2b_out", rdata, 8'h2E);
      addr = REG_OE;
      @(negedge clk);
      req = 1'b0;
      check("b2b_ack1", ack, 1);
      check("b2b_oe", rdata, 8'hFF);
      @(negedge clk);
      check("b2b_ack_drop", ack, 0);

      // Rise edge latency and W1C
      bus_write(REG_OE, 8'h00);
      ext_val = 8'h00; ext_en = 8'hFF;
      cycles(SETTLE);
      read_check("stat_idle", REG_IRQ_STAT, 8'h00);
      bus_write(REG_RISE_EN, 8'h01);
      cycles(2);
      ext_val[0] = 1'b1;
      for (int k = 1; k <= int'(LAT) + 1; k++) begin
         @(negedge clk);
         check("irq_lat", irq, (k == int'(LAT) + 1) ? 1 : 0);
      end
      read_check("stat_rise", REG_IRQ_STAT, 8'h01);
      bus_write(REG_IRQ_STAT, 8'h01);
      check("irq_clear", irq, 0);

      // Enabling while already high flags nothing
      ext_val[1] = 1'b1;
      cycles(SETTLE);
      bus_write(REG_RISE_EN, 8'h03);
      cycles(SETTLE);
      read_check("en_while_high", REG_IRQ_STAT, 8'h00);

      // Fall edge coinciding with W1C: set wins
      bus_write(REG_FALL_EN, 8'h80);
      ext_val[7] = 1'b1;
      cycles(SETTLE);
      ext_val[7] = 1'b0;
      cycles(SETTLE);
      read_check("stat_fall", REG_IRQ_STAT, 8'h80);
      ext_val[7] = 1'b1;
      cycles(SETTLE);
      ext_val[7] = 1'b0;
      cycles(LAT - 1);
      bus_write(REG_IRQ_STAT, 8'h80);
      read_check("set_wins", REG_IRQ_STAT, 8'h80);
      check("set_wins_irq", irq, 1);
      bus_write(REG_FALL_EN, 8'h00);
      read_check("disable_keeps", REG_IRQ_STAT, 8'h80);
      bus_write(REG_IRQ_STAT, 8'h80);
      read_check("w1c", REG_IRQ_STAT, 8'h00);

      // One-clock glitch on pad[3]
      bus_write(REG_RISE_EN, 8'h08);
      cycles(2);
      ext_val[3] = 1'b1;
      @(negedge clk);
      ext_val[3] = 1'b0;
      cycles(SETTLE);
`ifdef GPIO_BANK_DEBOUNCE_EN
      read_check("glitch_filtered", REG_IRQ_STAT, 8'h00);
      ext_val[3] = 1'b1;
      cycles(20);
      ext_val[3] = 1'b0;
      cycles(SETTLE);
      read_check("wide_pulse", REG_IRQ_STAT, 8'h08);
`else
      read_check("glitch_seen", REG_IRQ_STAT, 8'h08);
`endif

      // Reset while a read is in flight
      bus_write(REG_OUT, 8'h55);
      bus_write(REG_FALL_EN, 8'h0F);
      check("pre_rst_irq", irq, 1);
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = REG_OUT; rst = 1'b1;
      @(negedge clk);
      req = 1'b0; rst = 1'b0;
      check("midrst_ack", ack, 0);
      check("midrst_rdata", rdata, 0);
      check("midrst_irq", irq, 0);
      @(negedge clk);
      check("midrst_ack2", ack, 0);
      read_check("midrst_out", REG_OUT, 8'h00);
      read_check("midrst_oe", REG_OE, 8'h00);
      read_check("midrst_rise", REG_RISE_EN, 8'h00);
      read_check("midrst_fall", REG_FALL_EN, 8'h00);
      read_check("midrst_stat", REG_IRQ_STAT, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
- Parametrised bidirectional pad bank: WIDTH tristate pins, each with a registered output value and output enable.
- Input path per pin: synchroniser, then per-pin rise/fall edge detection into sticky interrupt status.
- Controlled over a simple single-cycle register bus from the SoC core; replaces hand-instantiated per-pin bidirectional buffers on the top-level io vector.

Parameters:
- WIDTH, 8, number of pins in the bank (1..32).
- SYNC_STAGES, 2, input synchroniser depth in flops (2..4).
- RESET_OE, 0, OE register value after reset (WIDTH bits, 0 = all pins input).
- DEBOUNCE_CYCLES, 16, filter length; used only with the optional feature.

Ports:
- clk  in  1  bank clock.
- rst  in  1  synchronous reset, active-high.
- req  in  1  bus request, single cycle.
- we  in  1  1 = write, 0 = read; qualified by req.
- addr  in  3  register index.
- wdata  in  WIDTH  write data.
- rdata  out  WIDTH  read data, valid when ack=1, 0 otherwise.
- ack  out  1  one-cycle acknowledge.
- irq  out  1  OR of IRQ_STAT bits.
- pad  inout  WIDTH  pins. pad[i] is driven with OUT[i] when OE[i]=1, otherwise high-Z.

Behaviour:
- Reset (rst=1 at posedge):
  - OUT=0, OE=RESET_OE.
  - RISE_EN=0, FALL_EN=0, IRQ_STAT=0.
  - Sync chain, in_prev and debounce state all 0.
  - rdata=0, ack=0, irq=0.
  - Reset overrides any req in the same cycle.
- Register map (addr):
  - 0 OUT rw.
  - 1 OE rw.
  - 2 IN ro; reads the synchronised (filtered) value; writes ignored.
  - 3 RISE_EN rw.
  - 4 FALL_EN rw.
  - 5 IRQ_STAT: read returns status; write clears each bit where wdata=1 (W1C).
  - 6 OUT_SET wo: OUT |= wdata; reads 0.
  - 7 OUT_CLR wo: OUT &= ~wdata; reads 0.
- Bus timing:
  - ack is asserted the cycle after req, for exactly one cycle.
  - Read data is sampled at the req edge and presented with ack.
  - Write effects are visible on pad and OUT from the edge where req is sampled, i.e. the cycle after req.
  - Back-to-back req on consecutive cycles is legal. Each req gets its own ack.
- Input path:
  - pad[i] passes through a SYNC_STAGES flop chain to give in_s[i].
  - in_prev is in_s delayed one clock.
  - rise = in_s & ~in_prev & RISE_EN; fall = ~in_s & in_prev & FALL_EN.
  - IRQ_STAT |= rise | fall, registered.
  - A pad change reaches IN after SYNC_STAGES clocks. The IRQ_STAT bit and irq assert SYNC_STAGES+1 clocks after the change.
- Simultaneous events:
  - A W1C write and a new edge on the same bit in the same cycle leave the bit set (set wins).
  - OUT_SET and OUT_CLR cannot coincide (one req per cycle).
- Enable handling:
  - Enabling RISE_EN while the pin is already high does not flag an edge. Only transitions flag.
  - Disabling an enable does not clear existing status.
- Loopback: a pin with OE=1 reads back its own driven value through the sync path.
- Reset mid-operation: a pending ack is dropped, and status and enables are lost.

Optional Feature:
- Macro: GPIO_BANK_DEBOUNCE_EN.
- Defined: a per-pin counter sits between in_s and the edge detector/IN.
  - The filtered value takes the new in_s only after in_s has differed from it for DEBOUNCE_CYCLES consecutive clocks.
  - Any return to the old value restarts the counter.
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - Added latency is DEBOUNCE_CYCLES clocks.
- Undefined: the filtered value is in_s directly. No counters are synthesised and DEBOUNCE_CYCLES is ignored.

Decomposition:
- Package gpio_bank_pkg holds the register address localparams (REG_OUT=0 .. REG_OUT_CLR=7) and the address width constant 3.
- Sub-module gpio_pad contains one pin: tristate driver, sync chain, optional debounce. It exposes in_f to the bank.
- gpio_bank holds the registers, bus decode and edge/IRQ logic, and generates WIDTH gpio_pad instances.

Test Plan:
- Reset: with RESET_OE=8'h00, all pads read Z externally. Reading addr 0–7 returns 0, ack exactly one cycle after each req, irq=0.
- Write OE=8'hFF, OUT=8'hA5 -> pad=8'hA5 the next cycle. After SYNC_STAGES clocks, a read of IN=8'hA5. Then OUT_SET 8'h0A -> 8'hAF, then OUT_CLR 8'h81 -> 8'h2E.
- OE=0, RISE_EN=8'h01, external pad[0] 0->1 -> IRQ_STAT=8'h01 and irq=1 exactly SYNC_STAGES+1 clocks later. Write 8'h01 to addr 5 -> irq=0.
- FALL_EN=8'h80, pad[7] 1->0 timed to coincide with a W1C of bit 7 -> bit 7 remains set.
- Glitch: pad[3] pulses high for 1 clock with RISE_EN[3]=1.
  - With GPIO_BANK_DEBOUNCE_EN: no status, and a 20-clock-wide pulse sets status.
  - Without the macro: the 1-clock pulse (aligned to clk) sets status.
- Assert rst while a read req is in flight -> ack stays 0 and all registers return to reset values the next cycle.
